// File: rtl/shift_arbiter.sv
// shift_arbiter: two requesters share one 32-bit logical right shifter.
// Each requester has a valid/ready handshake. There is one registered result
// slot, tagged with the ID of the requester that issued the operation.
// Default build: fixed priority to r0, with a starvation bound for r1.
// Define SHIFT_ARB_RR_EN to build a strict round-robin arbiter instead.

// 5-stage logarithmic barrel shifter (logical right, zero fill)
module right_shifter (
  input  logic [31:0] operand,
  input  logic [4:0]  shamt,
  output logic [31:0] result
);
  logic [5:0][31:0] stg;

  assign stg[0] = operand;
  for (genvar i = 0; i < 5; i++) begin : g_stage
    assign stg[i+1] = shamt[i] ? (stg[i] >> (1 << i)) : stg[i];
  end
  assign result = stg[5];
endmodule

module shift_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [31:0]      r0_operand,
  input  logic [4:0]       r0_shamt,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [31:0]      r1_operand,
  input  logic [4:0]       r1_shamt,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic             res_id,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);
  typedef enum logic {IDLE, HOLD} state_t;
  typedef struct packed {
    logic [31:0] operand;
    logic [4:0]  shamt;
  } req_t;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_limit_chk
    $error("STARVE_LIMIT must be in 1..255");
  end

  state_t      state, state_nxt;
  logic        can_accept;
  logic        gnt_r1;     // 1: grant points at r1, 0: at r0
  logic        acc0, acc1, acc;
  req_t        req_sel;
  logic [31:0] shift_out;

  // Slot is free when empty, or when it is being drained this cycle
  assign can_accept = (state == IDLE) || res_ready;

`ifdef SHIFT_ARB_RR_EN
  logic last_grant;

  // With both requesters valid, the grant alternates away from the last winner
  always_comb begin
    gnt_r1 = 1'b0;
    if (r1_valid && !r0_valid)     gnt_r1 = 1'b1;
    else if (r1_valid && r0_valid) gnt_r1 = ~last_grant;
  end

  // Remember the last winner; the reset value 1 makes the first contended grant go to r0
  always_ff @(posedge clock or negedge resetn)
    if (!resetn)  last_grant <= 1'b1;
    else if (acc) last_grant <= acc1;
`else
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
  logic [SW-1:0] starve_cnt;

  // r0 wins contention unless r1 has been stalled for LIMIT cycles
  always_comb begin
    gnt_r1 = 1'b0;
    if (r1_valid && !r0_valid)     gnt_r1 = 1'b1;
    else if (r1_valid && r0_valid) gnt_r1 = (starve_cnt == LIMIT);
  end

  // Count the cycles r1 waits; the count saturates and clears on r1 accept or when r1 drops valid
  always_ff @(posedge clock or negedge resetn)
    if (!resetn)                   starve_cnt <= '0;
    else if (!r1_valid || acc1)    starve_cnt <= '0;
    else if (starve_cnt != LIMIT)  starve_cnt <= starve_cnt + 1'b1;
`endif

  assign r0_ready = can_accept && r0_valid && !gnt_r1;
  assign r1_ready = can_accept && r1_valid &&  gnt_r1;
  assign acc0     = r0_valid && r0_ready;
  assign acc1     = r1_valid && r1_ready;
  assign acc      = acc0 || acc1;

  assign req_sel  = gnt_r1 ? req_t'{r1_operand, r1_shamt} : req_t'{r0_operand, r0_shamt};

  right_shifter u_shift (
    .operand (req_sel.operand),
    .shamt   (req_sel.shamt),
    .result  (shift_out)
  );

  // State register
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;

  // Next state: an accept fills the slot, and a drain with no accept empties it
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (acc) state_nxt = HOLD;
      HOLD: if (res_ready && !acc) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Result slot and accept counter; these update only on an accept
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      res_data <= '0;
      res_id   <= 1'b0;
      op_count <= '0;
    end else if (acc) begin
      res_data <= shift_out;
      res_id   <= acc1;
      op_count <= op_count + 1'b1;
    end

  assign res_valid = (state == HOLD);
  assign busy      = res_valid;
endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter. Define SHIFT_ARB_RR_EN for the round-robin build.
module tb_shift_arbiter;
  logic        clk = 1'b0;
  logic        resetn;
  logic        r0_valid, r0_ready, r1_valid, r1_ready;
  logic [31:0] r0_operand, r1_operand;
  logic [4:0]  r0_shamt, r1_shamt;
  logic        res_valid, res_ready, res_id, busy;
  logic [31:0] res_data;
  logic [15:0] op_count;

  typedef struct {
    logic [31:0] data;
    logic        id;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0, n_fail = 0;
  logic [15:0] exp_cnt;
  logic        exp_valid;
  logic [31:0] last_data;
  logic        last_id;

  always #5 clk = ~clk;

  shift_arbiter dut (
    .clock(clk), .resetn(resetn),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_operand(r0_operand), .r0_shamt(r0_shamt),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_operand(r1_operand), .r1_shamt(r1_shamt),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
    .busy(busy), .op_count(op_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference shift built bit by bit
  function automatic logic [31:0] ref_shr(input logic [31:0] v, input logic [4:0] s);
    logic [31:0] r = '0;
    for (int k = 0; k + int'(s) < 32; k++) r[k] = v[k + int'(s)];
    return r;
  endfunction

  task automatic exp_rdy(input string tag, input logic e0, input logic e1);
    #1;
    chk({tag, "_r0_ready"}, 32'(r0_ready), 32'(e0));
    chk({tag, "_r1_ready"}, 32'(r1_ready), 32'(e1));
  endtask

  // One clock cycle: observe handshakes, push expectations, then pop/compare after the edge
  task automatic step();
    logic a0, a1, hold;
    exp_t e;
    #1;
    a0 = r0_valid && r0_ready;
    a1 = r1_valid && r1_ready;
    chk("single_grant", 32'(a0 && a1), 32'd0);
    if (a0)      sb.push_back(exp_t'{ref_shr(r0_operand, r0_shamt), 1'b0});
    else if (a1) sb.push_back(exp_t'{ref_shr(r1_operand, r1_shamt), 1'b1});
    hold = exp_valid && !res_ready;
    @(posedge clk); #1;
    if (a0 || a1) begin
      exp_cnt++;
      exp_valid = 1'b1;
      e = sb.pop_front();
      chk("res_data", res_data, e.data);
      chk("res_id", 32'(res_id), 32'(e.id));
      last_data = e.data;
      last_id   = e.id;
    end else begin
      exp_valid = hold;
      if (hold) begin
        chk("held_data", res_data, last_data);
        chk("held_id", 32'(res_id), 32'(last_id));
      end
    end
    chk("res_valid", 32'(res_valid), 32'(exp_valid));
    chk("busy", 32'(busy), 32'(exp_valid));
    chk("op_count", 32'(op_count), 32'(exp_cnt));
  endtask

  task automatic model_reset();
    exp_cnt = '0; exp_valid = 1'b0; last_data = '0; last_id = 1'b0;
    sb.delete();
  endtask

  initial begin
    resetn = 1'b0;
    r0_valid = 0; r1_valid = 0; res_ready = 0;
    r0_operand = '0; r1_operand = '0; r0_shamt = '0; r1_shamt = '0;
    model_reset();
    #1;
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_res_id", 32'(res_id), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b1;

    // 1: shamt 31 keeps only the MSB
    r0_valid = 1; r0_operand = 32'h8000_0000; r0_shamt = 5'd31; res_ready = 1;
    exp_rdy("t1", 1'b1, 1'b0);
    step();
    chk("t1_data", res_data, 32'h1);
    chk("t1_cnt", 32'(op_count), 32'd1);

    // 2: shamt 0 passes operand through; then back-to-back r0 results
    r0_valid = 0; r1_valid = 1; r1_operand = 32'hDEAD_BEEF; r1_shamt = 5'd0;
    exp_rdy("t2", 1'b0, 1'b1);
    step();
    chk("t2_data", res_data, 32'hDEAD_BEEF);
    r1_valid = 0; r0_valid = 1;
    for (int i = 0; i < 3; i++) begin
      r0_operand = 32'hF0F0_0000 + 32'(i); r0_shamt = 5'(4 * i + 1);
      exp_rdy("t2_b2b", 1'b1, 1'b0);
      step();
    end
    r0_valid = 0;
    step();

    // 3: result held under backpressure; accept happens in the same cycle res_ready rises
    res_ready = 0; r0_valid = 1; r0_operand = 32'h1234_5678; r0_shamt = 5'd8;
    step();
    r1_valid = 1; r1_operand = 32'hCAFE_F00D; r1_shamt = 5'd16;
    for (int i = 0; i < 5; i++) begin
      exp_rdy("t3_stall", 1'b0, 1'b0);
      step();
    end
    res_ready = 1;
    exp_rdy("t3_release", 1'b0, 1'b1);
    step();

    // 4: both valid continuously
    for (int i = 0; i < 10; i++) begin
      r0_operand = $urandom; r0_shamt = 5'($urandom);
      r1_operand = $urandom; r1_shamt = 5'($urandom);
`ifdef SHIFT_ARB_RR_EN
      exp_rdy("t4_rr", (i % 2) == 0, (i % 2) == 1);
`else
      exp_rdy("t4_fixed", (i % 5) != 4, (i % 5) == 4);
`endif
      step();
    end

    // random mix of valids and backpressure
    for (int i = 0; i < 60; i++) begin
      r0_valid = 1'($urandom); r1_valid = 1'($urandom); res_ready = 1'($urandom);
      r0_operand = $urandom; r0_shamt = 5'($urandom);
      r1_operand = $urandom; r1_shamt = 5'($urandom);
      step();
    end

    // 5: async reset while a result is held
    r1_valid = 0; r0_valid = 1; res_ready = 0; r0_operand = 32'hFFFF_FFFF; r0_shamt = 5'd3;
    step();
    r0_valid = 0;
    #1 resetn = 1'b0;
    #1;
    chk("t5_res_valid", 32'(res_valid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_op_count", 32'(op_count), 32'd0);
    model_reset();
    @(posedge clk); #1;
    resetn = 1'b1;
    r1_valid = 1; r1_operand = 32'h0000_FF00; r1_shamt = 5'd4; res_ready = 1;
    exp_rdy("t5_after", 1'b0, 1'b1);
    step();
    chk("t5_data", res_data, 32'h0000_0FF0);
    r1_valid = 0;

    // 6: op_count wrap
    r0_valid = 1; res_ready = 1;
    while (exp_cnt != 16'hFFFF) begin
      r0_operand = $urandom; r0_shamt = 5'($urandom);
      step();
    end
    chk("t6_full", 32'(op_count), 32'h0000_FFFF);
    step();
    chk("t6_wrap", 32'(op_count), 32'd0);
    r0_valid = 0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
